// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache frame address layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IDX_W   = $clog2(ICACHE_NFRAMES);
    localparam int ICACHE_TAG_W   = 30 - ICACHE_IDX_W;

    // Layout of a byte address as seen by the default-sized instruction cache.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_frame_array.sv
// Storage for the direct-mapped instruction cache: valid/tag/data per frame,
// combinational read port, synchronous write port, valid bits cleared on reset.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES,
    parameter int IDX_W   = $clog2(NFRAMES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  word_t            wr_data
);

    logic [NFRAMES-1:0] valid;
    logic [TAG_W-1:0]   tags [NFRAMES];
    word_t              data [NFRAMES];

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; a cleared valid bit hides stale contents.
    always_ff @(posedge CLK) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-frame instruction cache with a single outstanding
// fill and saturating hit/miss counters.
//   state | meaning
//   IDLE  | lookup current request; hit served combinationally, miss latched
//   FILL  | reading latched miss address from memory until iwait drops
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output word_t hit_count,
    output word_t miss_count
);

    localparam int IDX_W = $clog2(NFRAMES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_n;
    word_t  miss_addr, hit_cnt, miss_cnt;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             hit, start_miss, fill_we;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .NFRAMES (NFRAMES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (miss_addr[IDX_W+1:2]),
        .wr_tag   (miss_addr[31:IDX_W+2]),
        .wr_data  (iload)
    );

    // Everything is held quiet while RST is high so a reset cycle never hits,
    // requests memory, or writes a frame.
    always_comb begin
        state_n    = state;
        hit        = 1'b0;
        start_miss = 1'b0;
        fill_we    = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (imemREN) begin
                        if (rd_valid && (rd_tag == req_tag)) begin
                            hit = 1'b1;
                        end else begin
                            start_miss = 1'b1;
                            state_n    = FILL;
                        end
                    end
                end
                FILL: begin
                    iREN  = 1'b1;
                    iaddr = miss_addr;
                    if (!iwait) begin
                        fill_we = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign ihit     = hit;
    assign imemload = hit ? rd_data : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_n;
            if (start_miss) begin
                miss_addr <= {imemaddr[31:2], 2'b00};
            end
            if (hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

endmodule
